stream_mux_rr: RTL and testbench

Parametrised N-input, W-bit registered stream multiplexer with valid/ready handshakes and packet locking, the clocked successor of the combinational 2:1 mux blocks. It selects one of N input streams, by round-robin arbitration or by an external select, and forwards whole packets (Last-delimited) through a one-stage output register. It sits between multiple traffic sources and a single downstream consumer, such as a crypto core input port.

---
 rtl/stream_mux_rr.sv | 129 ++++++++++++
 tb/tb_stream_mux_rr.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input packet-locking stream mux, round-robin (MODE=0) or external select (MODE=1).
// Latency: 1 cycle from input acceptance to Out_Valid; full 1 beat/cycle throughput.
// Backpressure: In_Ready is granted only when the output register can load (empty or being consumed).
//
// Ports:
//   Clk, Rst                     clock (rising edge), synchronous active-high reset
//   In_Data/In_Valid/In_Last     N input streams, channel i at In_Data[i*W +: W]
//   In_Ready                     per-channel ready, at most one bit high
//   Sel                          channel select, used only when MODE=1
//   Out_Data/Out_Last/Out_Chan   registered output beat and its source channel
//   Out_Valid/Out_Ready          output handshake
module stream_mux_rr #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int MODE = 0,
    localparam int CW  = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [N*W-1:0] In_Data,
    input  logic [N-1:0]   In_Valid,
    input  logic [N-1:0]   In_Last,
    output logic [N-1:0]   In_Ready,
    input  logic [CW-1:0]  Sel,
    output logic [W-1:0]   Out_Data,
    output logic           Out_Last,
    output logic [CW-1:0]  Out_Chan,
    output logic           Out_Valid,
    input  logic           Out_Ready
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [CW-1:0] ptr;
    logic [CW-1:0] lock_ch;
    logic [CW-1:0] grant;
    logic          grant_valid;
    logic          can_load;
    logic          accept;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic          sel_valid;

    // Grant selection. Arbitration only happens in IDLE; once a multi-beat
    // packet has started the locked channel owns the output until Last.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (state == LOCK) begin
            grant       = lock_ch;
            grant_valid = 1'b1;
        end else if (MODE == 1) begin
            grant       = Sel;
            grant_valid = (int'(Sel) < N);
        end else begin
            // Walk offsets from N down to 1 so the nearest valid channel after
            // ptr is the last assignment and therefore wins.
            for (int k = N; k >= 1; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (In_Valid[i] && (i == (int'(ptr) + k) % N)) begin
                        grant       = CW'(i);
                        grant_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Mux the granted channel's beat. Written as a compare loop so an
    // out-of-range Sel never indexes past the input vectors.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == CW'(i)) begin
                sel_data  = In_Data[i*W +: W];
                sel_last  = In_Last[i];
                sel_valid = In_Valid[i];
            end
        end
    end

    // Ready passes straight through from Out_Ready so a consumed beat can be
    // replaced in the same cycle without a bubble.
    assign can_load = !Out_Valid || Out_Ready;
    assign accept   = !Rst && can_load && grant_valid && sel_valid;

    always_comb begin
        In_Ready = '0;
        for (int i = 0; i < N; i++) begin
            In_Ready[i] = !Rst && can_load && grant_valid && (grant == CW'(i));
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            ptr       <= CW'(N - 1);
            lock_ch   <= '0;
            Out_Data  <= '0;
            Out_Last  <= 1'b0;
            Out_Chan  <= '0;
            Out_Valid <= 1'b0;
        end else begin
            if (accept) begin
                Out_Data  <= sel_data;
                Out_Last  <= sel_last;
                Out_Chan  <= grant;
                Out_Valid <= 1'b1;
                if (state == IDLE) begin
                    // First beat of a packet: advance round-robin pointer and
                    // lock only if the packet continues past this beat.
                    ptr <= grant;
                    if (!sel_last) begin
                        state   <= LOCK;
                        lock_ch <= grant;
                    end
                end else if (sel_last) begin
                    state <= IDLE;
                end
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr (RR instance plus two external-select instances).
// Expected output order comes from a queue-level round-robin model of whole packets.
// A negedge monitor pops the scoreboard on every output handshake of the round-robin instance.
module tb_stream_mux_rr;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] chan;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Round-robin instance
    logic [N*W-1:0] d0_in_data;
    logic [N-1:0]   d0_in_valid, d0_in_last, d0_in_ready;
    logic [1:0]     d0_sel;
    logic [W-1:0]   d0_out_data;
    logic           d0_out_last, d0_out_valid, d0_out_ready;
    logic [1:0]     d0_out_chan;

    // External-select instance, N=4
    logic [N*W-1:0] m1_in_data;
    logic [N-1:0]   m1_in_valid, m1_in_last, m1_in_ready;
    logic [1:0]     m1_sel;
    logic [W-1:0]   m1_out_data;
    logic           m1_out_last, m1_out_valid, m1_out_ready;
    logic [1:0]     m1_out_chan;

    // External-select instance, N=3 (Sel=3 is out of range)
    logic [3*W-1:0] m2_in_data;
    logic [2:0]     m2_in_valid, m2_in_last, m2_in_ready;
    logic [1:0]     m2_sel;
    logic [W-1:0]   m2_out_data;
    logic           m2_out_last, m2_out_valid, m2_out_ready;
    logic [1:0]     m2_out_chan;

    stream_mux_rr #(.W(W), .N(N), .MODE(0)) dut0 (
        .Clk(clk), .Rst(rst), .In_Data(d0_in_data), .In_Valid(d0_in_valid),
        .In_Last(d0_in_last), .In_Ready(d0_in_ready), .Sel(d0_sel),
        .Out_Data(d0_out_data), .Out_Last(d0_out_last), .Out_Chan(d0_out_chan),
        .Out_Valid(d0_out_valid), .Out_Ready(d0_out_ready));

    stream_mux_rr #(.W(W), .N(N), .MODE(1)) dut1 (
        .Clk(clk), .Rst(rst), .In_Data(m1_in_data), .In_Valid(m1_in_valid),
        .In_Last(m1_in_last), .In_Ready(m1_in_ready), .Sel(m1_sel),
        .Out_Data(m1_out_data), .Out_Last(m1_out_last), .Out_Chan(m1_out_chan),
        .Out_Valid(m1_out_valid), .Out_Ready(m1_out_ready));

    stream_mux_rr #(.W(W), .N(3), .MODE(1)) dut2 (
        .Clk(clk), .Rst(rst), .In_Data(m2_in_data), .In_Valid(m2_in_valid),
        .In_Last(m2_in_last), .In_Ready(m2_in_ready), .Sel(m2_sel),
        .Out_Data(m2_out_data), .Out_Last(m2_out_last), .Out_Chan(m2_out_chan),
        .Out_Valid(m2_out_valid), .Out_Ready(m2_out_ready));

    beat_t      chq[N][$];    // driver: beats still to be offered per channel
    beat_t      mdl_q[N][$];  // model: packets not yet scheduled per channel
    exp_t       exp_q[$];     // scoreboard
    int         last_ch = N - 1;
    int         checks = 0;
    int         passes = 0;
    bit         sb_en = 1'b0;
    bit         gaps_en = 1'b0;
    int         or_mode = 0;  // 0: Out_Ready=1, 1: random, 2: Out_Ready=0
    bit         mid[N];
    logic [N-1:0] acc;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [7:0] base);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = base + 8'(j);
            b.last = (j == len - 1);
            chq[ch].push_back(b);
            mdl_q[ch].push_back(b);
        end
    endtask

    // Whole-packet round-robin: next channel after the previous winner that
    // has a pending packet sends its entire packet.
    task automatic compute_expected();
        bit    any;
        bit    done;
        int    c;
        beat_t b;
        exp_t  e;
        do begin
            any = 1'b0;
            for (int k = 1; k <= N && !any; k++) begin
                c = (last_ch + k) % N;
                if (mdl_q[c].size() > 0) begin
                    any     = 1'b1;
                    last_ch = c;
                    done    = 1'b0;
                    while (!done && mdl_q[c].size() > 0) begin
                        b      = mdl_q[c].pop_front();
                        e.data = b.data;
                        e.last = b.last;
                        e.chan = 2'(c);
                        exp_q.push_back(e);
                        done   = b.last;
                    end
                end
            end
        end while (any);
    endtask

    // Channels waiting to start a packet are always valid; only the channel
    // that is mid-packet may insert gaps.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (chq[i].size() > 0) begin
                d0_in_valid[i]       = (mid[i] && gaps_en) ? ($urandom_range(3) != 0) : 1'b1;
                d0_in_data[i*W +: W] = chq[i][0].data;
                d0_in_last[i]        = chq[i][0].last;
            end else begin
                d0_in_valid[i] = 1'b0;
            end
        end
        case (or_mode)
            0:       d0_out_ready = 1'b1;
            1:       d0_out_ready = ($urandom_range(2) != 0);
            default: d0_out_ready = 1'b0;
        endcase
    endtask

    task automatic step_pre();
        @(negedge clk);
        acc = d0_in_valid & d0_in_ready;
    endtask

    task automatic step_post();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && chq[i].size() > 0) begin
                mid[i] = !chq[i][0].last;
                void'(chq[i].pop_front());
            end
        end
        drive();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || d0_out_valid) && t < 3000) begin
            step_pre();
            step_post();
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (sb_en && !rst && d0_out_valid && d0_out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_data", d0_out_data, mon_e.data);
                chk("sb_last", d0_out_last, mon_e.last);
                chk("sb_chan", d0_out_chan, mon_e.chan);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        d0_in_valid = '1; d0_in_last = '1; d0_in_data = '0; d0_sel = '0; d0_out_ready = 1'b1;
        m1_in_valid = '0; m1_in_last = '0; m1_in_data = '0; m1_sel = '0; m1_out_ready = 1'b1;
        m2_in_valid = '0; m2_in_last = '0; m2_in_data = '0; m2_sel = '0; m2_out_ready = 1'b1;
        for (int i = 0; i < N; i++) mid[i] = 1'b0;

        // Reset with every channel valid
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", d0_in_ready, 0);
            chk("rst_out_valid", d0_out_valid, 0);
            chk("rst_out_data", d0_out_data, 0);
            chk("rst_m1_in_ready", m1_in_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_grant", d0_in_ready, 4'b0001);
        d0_in_valid = '0;
        @(posedge clk); #1;
        sb_en = 1'b1;

        // Round robin over single-beat packets, one per cycle
        add_pkt(0, 1, 8'h10); add_pkt(1, 1, 8'h21); add_pkt(2, 1, 8'h32);
        add_pkt(3, 1, 8'h43); add_pkt(0, 1, 8'h10);
        compute_expected();
        drive();
        step_pre();
        t = 0;
        while (!d0_out_valid && t < 20) begin step_post(); step_pre(); t++; end
        for (int k = 0; k < 5; k++) begin
            chk("rr_valid", d0_out_valid, 1);
            chk("rr_chan", d0_out_chan, k % 4);
            step_post();
            step_pre();
        end
        step_post();
        drain();

        // Packet lock: 3-beat packet on ch1 while ch2 waits
        add_pkt(1, 3, 8'hA0); add_pkt(2, 1, 8'h2F);
        compute_expected();
        drive();
        drain();

        // Backpressure holds the output and blocks all inputs
        or_mode = 2;
        add_pkt(0, 1, 8'h55); add_pkt(1, 1, 8'h66);
        compute_expected();
        drive();
        step_pre();
        t = 0;
        while (!d0_out_valid && t < 20) begin step_post(); step_pre(); t++; end
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_data", d0_out_data, 8'h55);
            chk("bp_in_ready", d0_in_ready, 0);
            if (k == 2) or_mode = 0;
            step_post();
            step_pre();
        end
        step_post();
        step_pre();
        chk("bp_next_valid", d0_out_valid, 1);
        chk("bp_next_chan", d0_out_chan, 1);
        chk("bp_next_data", d0_out_data, 8'h66);
        step_post();
        drain();

        // Randomised traffic with gaps inside packets and random Out_Ready
        or_mode = 1;
        gaps_en = 1'b1;
        repeat (30) begin
            for (int c = 0; c < N; c++) begin
                repeat ($urandom_range(2)) add_pkt(c, $urandom_range(4, 1), 8'($urandom));
            end
            compute_expected();
            drive();
            drain();
        end
        or_mode = 0;
        gaps_en = 1'b0;
        drive();

        // Reset in the middle of a 4-beat packet on ch3
        sb_en = 1'b0;
        d0_in_valid = 4'b1000; d0_in_data[3*W +: W] = 8'h30; d0_in_last = '0;
        @(posedge clk); #1;
        d0_in_data[3*W +: W] = 8'h31;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", d0_in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        d0_in_valid = 4'b1001;
        d0_in_data[0 +: W] = 8'h05;
        d0_in_last = 4'b0001;
        @(negedge clk);
        chk("midrst_out_valid", d0_out_valid, 0);
        chk("midrst_grant", d0_in_ready, 4'b0001);
        @(posedge clk); #1;
        d0_in_valid = '0;
        @(negedge clk);
        chk("midrst_out_chan", d0_out_chan, 0);
        chk("midrst_out_data", d0_out_data, 8'h05);

        // External select: Sel change during a locked packet is ignored
        @(posedge clk); #1;
        m1_sel = 2'd2;
        m1_in_valid = 4'b1100;
        m1_in_data[2*W +: W] = 8'hB0; m1_in_last[2] = 1'b0;
        m1_in_data[3*W +: W] = 8'hC0; m1_in_last[3] = 1'b1;
        @(negedge clk);
        chk("sel_first_ready", m1_in_ready, 4'b0100);
        @(posedge clk); #1;
        m1_sel = 2'd3;
        m1_in_data[2*W +: W] = 8'hB1; m1_in_last[2] = 1'b1;
        @(negedge clk);
        chk("sel_lock_ready", m1_in_ready, 4'b0100);
        chk("sel_beat1_chan", m1_out_chan, 2);
        chk("sel_beat1_data", m1_out_data, 8'hB0);
        @(posedge clk); #1;
        m1_in_valid[2] = 1'b0;
        @(negedge clk);
        chk("sel_beat2_chan", m1_out_chan, 2);
        chk("sel_beat2_data", m1_out_data, 8'hB1);
        chk("sel_beat2_last", m1_out_last, 1);
        chk("sel_after_last_ready", m1_in_ready, 4'b1000);
        @(posedge clk); #1;
        m1_in_valid = '0;
        @(negedge clk);
        chk("sel_ch3_chan", m1_out_chan, 3);
        chk("sel_ch3_data", m1_out_data, 8'hC0);

        // Out-of-range select on N=3
        m2_sel = 2'd3;
        m2_in_valid = 3'b111;
        m2_in_last = 3'b111;
        #1;
        chk("sel_oor_ready", m2_in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sel_oor_ready2", m2_in_ready, 0);
        chk("sel_oor_out_valid", m2_out_valid, 0);
        m2_sel = 2'd1;
        #1;
        chk("sel_inrange_ready", m2_in_ready, 3'b010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
